line_window_3x3: RTL and testbench

Streaming 3x3 neighbourhood generator that sits directly upstream of the 3x3 kernel stage (smoothing / Laplacian edge / passthrough). It accepts a raster-scan pixel stream, buffers the two previous image rows, and presents each interior 3x3 window on nine parallel pixel outputs `p1`..`p9` with a valid/ready handshake. One window is emitted per accepted input pixel once two full rows and two columns have been seen.

---
 rtl/img_pkg.sv | 14 +
 rtl/row_delay.sv | 42 ++++
 rtl/line_window_3x3.sv | 165 ++++++++++++++++
 tb/tb_line_window_3x3.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: default pixel width, pixel type and kernel mode codes.
package img_pkg;

  localparam int unsigned PIX_W_DEF = 4;

  typedef logic [PIX_W_DEF-1:0] pix_t;

  typedef enum logic [1:0] {
    ModeSmooth = 2'd0,
    ModeEdge   = 2'd1,
    ModePass   = 2'd2
  } kern_mode_e;

endpackage

// File: rtl/row_delay.sv
// Single-row delay line: on each enable returns the sample written Depth enables earlier.
module row_delay #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  // Contents deliberately unreset so the array can map onto RAM.
  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  ptr_q, ptr_d;

  assign q_o = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PtrW'(Depth - 1)) ? '0 : ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[ptr_q] <= d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/line_window_3x3.sv
// Streaming 3x3 window generator over a raster pixel stream with valid/ready handshake.
// Optional centre coordinate outputs are enabled by defining LINEWIN_COORD_EN.
module line_window_3x3
  import img_pkg::*;
#(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64,
  parameter int unsigned PIX_W = PIX_W_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [PIX_W-1:0]         in_pix_i,
  input  logic                     in_sof_i,
  input  logic                     out_ready_i,
`ifdef LINEWIN_COORD_EN
  output logic [$clog2(IMG_W)-1:0] out_x_o,
  output logic [$clog2(IMG_H)-1:0] out_y_o,
`endif
  output logic                     out_valid_o,
  output logic [PIX_W-1:0]         p1_o,
  output logic [PIX_W-1:0]         p2_o,
  output logic [PIX_W-1:0]         p3_o,
  output logic [PIX_W-1:0]         p4_o,
  output logic [PIX_W-1:0]         p5_o,
  output logic [PIX_W-1:0]         p6_o,
  output logic [PIX_W-1:0]         p7_o,
  output logic [PIX_W-1:0]         p8_o,
  output logic [PIX_W-1:0]         p9_o
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  logic             accept, win_load;
  logic [XW-1:0]    col_q, col_d, cur_col;
  logic [YW-1:0]    row_q, row_d, cur_row;
  logic [PIX_W-1:0] buf_a, buf_b;
  logic [PIX_W-1:0] live [3];
  // Per window row: [0] holds column c-2, [1] holds c-1; column c is the live tap.
  logic [PIX_W-1:0] sr_q [3][2];
  logic [PIX_W-1:0] sr_d [3][2];
  logic [PIX_W-1:0] win_q [9];
  logic [PIX_W-1:0] win_d [9];
  logic             out_valid_q, out_valid_d;

  assign in_ready_o = !out_valid_q || out_ready_i;

  row_delay #(
    .Depth (IMG_W),
    .Width (PIX_W)
  ) u_row_a (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (accept),
    .d_i    (in_pix_i),
    .q_o    (buf_a)
  );

  row_delay #(
    .Depth (IMG_W),
    .Width (PIX_W)
  ) u_row_b (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (accept),
    .d_i    (buf_a),
    .q_o    (buf_b)
  );

  always_comb begin
    accept   = in_valid_i && in_ready_o;
    cur_col  = in_sof_i ? '0 : col_q;
    cur_row  = in_sof_i ? '0 : row_q;
    win_load = accept && (cur_row >= YW'(2)) && (cur_col >= XW'(2));

    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (cur_col == XW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (cur_row == YW'(IMG_H - 1)) ? '0 : cur_row + YW'(1);
      end else begin
        col_d = cur_col + XW'(1);
        row_d = cur_row;
      end
    end

    live[0] = buf_b;
    live[1] = buf_a;
    live[2] = in_pix_i;

    sr_d        = sr_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    for (int r = 0; r < 3; r++) begin
      if (accept) begin
        sr_d[r][0] = sr_q[r][1];
        sr_d[r][1] = live[r];
      end
      if (win_load) begin
        win_d[3*r]     = sr_q[r][0];
        win_d[3*r + 1] = sr_q[r][1];
        win_d[3*r + 2] = live[r];
      end
    end
    if (win_load) begin
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        sr_q[r][0] <= '0;
        sr_q[r][1] <= '0;
      end
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      sr_q        <= sr_d;
      win_q       <= win_d;
    end
  end

`ifdef LINEWIN_COORD_EN
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else if (win_load) begin
      x_q <= cur_col - XW'(1);
      y_q <= cur_row - YW'(1);
    end
  end

  assign out_x_o = x_q;
  assign out_y_o = y_q;
`endif

  assign out_valid_o = out_valid_q;
  assign p1_o = win_q[0];
  assign p2_o = win_q[1];
  assign p3_o = win_q[2];
  assign p4_o = win_q[3];
  assign p5_o = win_q[4];
  assign p6_o = win_q[5];
  assign p7_o = win_q[6];
  assign p8_o = win_q[7];
  assign p9_o = win_q[8];

endmodule

// File: tb/tb_line_window_3x3.sv
// Self-checking bench for line_window_3x3: frame-image reference model plus directed and random runs.
module tb_line_window_3x3;

  localparam int W = 5;
  localparam int H = 4;

  logic       clk, rst_n;
  logic       in_valid, in_sof, out_ready;
  logic [3:0] in_pix;
  logic       in_ready, out_valid;
  logic [3:0] p [9];
`ifdef LINEWIN_COORD_EN
  logic [2:0] out_x;
  logic [1:0] out_y;
`endif

  int errors = 0;
  int checks = 0;

  line_window_3x3 #(
    .IMG_W (W),
    .IMG_H (H),
    .PIX_W (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_pix_i    (in_pix),
    .in_sof_i    (in_sof),
    .out_ready_i (out_ready),
`ifdef LINEWIN_COORD_EN
    .out_x_o     (out_x),
    .out_y_o     (out_y),
`endif
    .out_valid_o (out_valid),
    .p1_o        (p[0]),
    .p2_o        (p[1]),
    .p3_o        (p[2]),
    .p4_o        (p[3]),
    .p5_o        (p[4]),
    .p6_o        (p[5]),
    .p7_o        (p[6]),
    .p8_o        (p[7]),
    .p9_o        (p[8])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the current frame is kept as an image; each window is cut out of it.
  logic [3:0] img [H][W];
  int         m_r, m_c, e_r, e_c, m_x, m_y;
  bit         m_valid, m_acc;
  logic [3:0] m_win [9];

  always_comb begin
    e_r   = in_sof ? 0 : m_r;
    e_c   = in_sof ? 0 : m_c;
    m_acc = in_valid && (!m_valid || out_ready);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r <= 0;
      m_c <= 0;
      m_valid <= 1'b0;
      m_x <= 0;
      m_y <= 0;
      for (int k = 0; k < 9; k++) m_win[k] <= '0;
    end else begin
      if (m_acc) begin
        img[e_r][e_c] <= in_pix;
        if (e_c == W - 1) begin
          m_c <= 0;
          m_r <= (e_r == H - 1) ? 0 : e_r + 1;
        end else begin
          m_c <= e_c + 1;
          m_r <= e_r;
        end
      end
      if (m_acc && e_r >= 2 && e_c >= 2) begin
        m_valid <= 1'b1;
        m_x <= e_c - 1;
        m_y <= e_r - 1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            m_win[3*i + j] <= (i == 2 && j == 2) ? in_pix : img[e_r - 2 + i][e_c - 2 + j];
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Windows the DUT hands over, in order, for literal checks.
  logic [35:0] got_q [$];
  int          gx_q [$];
  int          gy_q [$];

  function automatic logic [35:0] cat9();
    return {p[0], p[1], p[2], p[3], p[4], p[5], p[6], p[7], p[8]};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", out_valid, m_valid);
      chk("in_ready", in_ready, !m_valid || out_ready);
      if (m_valid) begin
        for (int k = 0; k < 9; k++) chk($sformatf("p%0d", k + 1), p[k], m_win[k]);
`ifdef LINEWIN_COORD_EN
        chk("out_x", out_x, m_x);
        chk("out_y", out_y, m_y);
`endif
      end
      if (out_valid && out_ready) begin
        got_q.push_back(cat9());
`ifdef LINEWIN_COORD_EN
        gx_q.push_back(int'(out_x));
        gy_q.push_back(int'(out_y));
`endif
      end
    end
  end

  function automatic logic [3:0] pat(input int k);
    return 4'((5 * (k / W) + (k % W)) % 16);
  endfunction

  task automatic send_pix(input logic [3:0] v, input bit sof);
    bit acc, done;
    in_valid = 1'b1;
    in_pix   = v;
    in_sof   = sof;
    done     = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #2;
      done = acc;
    end
    if (!done) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_range(input int first, input int n, input bit sof_first);
    for (int k = first; k < first + n; k++) send_pix(pat(k), sof_first && k == first);
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic stall_ctl();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(posedge clk);
      #1;
      seen = out_valid;
    end
    if (!seen) chk("stall_wait_timeout", 0, 1);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("held_window", cat9(), 36'h012567ABC);
      chk("held_in_ready", in_ready, 0);
      @(posedge clk);
    end
    #1;
    out_ready = 1'b1;
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_windows"}, got_q.size(), 6);
    if (got_q.size() == 6) begin
      chk({tag, "_first"}, got_q[0], 36'h012567ABC);
      chk({tag, "_last"}, got_q[5], 36'h789CDE123);
    end
    got_q.delete();
    gx_q.delete();
    gy_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_pix = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_window", cat9(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #2;

    // Full frame, no back-pressure.
    send_range(0, W * H, 1'b1);
    drain();
`ifdef LINEWIN_COORD_EN
    chk("coord_count", gx_q.size(), 6);
    for (int k = 0; k < 6 && k < gx_q.size(); k++) begin
      chk($sformatf("coord_x%0d", k), gx_q[k], (k % 3) + 1);
      chk($sformatf("coord_y%0d", k), gy_q[k], (k / 3) + 1);
    end
`endif
    check_frame("frame1");

    // Back-pressure on the first window.
    fork
      send_range(0, W * H, 1'b1);
      stall_ctl();
    join
    drain();
    check_frame("stall");

    // Start of frame arrives on the 8th pixel.
    send_range(0, 7, 1'b1);
    send_range(0, 12, 1'b1);
    chk("resync_no_early_window", got_q.size() + int'(out_valid), 0);
    send_range(12, 8, 1'b0);
    drain();
    check_frame("resync");

    // Reset with a window pending.
    send_range(0, 13, 1'b1);
    chk("pending_before_rst", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_drops_valid", out_valid, 0);
    got_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    send_range(0, W * H, 1'b0);
    drain();
    check_frame("after_rst");

    // Random traffic, random pixels, occasional frame restarts.
    repeat (1500) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_pix    = 4'($urandom);
      in_sof    = ($urandom_range(0, 49) == 0);
      @(posedge clk);
      #2;
    end
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
